cpu_controller_p: RTL and testbench

Parametrised fetch/decode/execute controller for the 16-bit CPU. It holds the PC, the IR and the control FSM. Instruction memory sits outside the block behind a request/valid handshake, so wait states are tolerated and a watchdog bounds them. The block drives data-memory, register-file and ALU controls to the datapath; the branch opcodes are optional.

---
 rtl/cpu_controller_p.sv | 190 +++++++++++++++++++
 tb/tb_cpu_controller_p.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller_p.sv
// cpu_controller_p: fetch/decode/execute controller for the 16-bit CPU.
// Holds PC, IR and the control FSM. Instruction memory is reached through a
// request/valid handshake, and a watchdog bounds the wait for the word.
// Optional feature: define CTRL_BRANCH_EN to execute opcode 6 as JMP and
// opcode 7 as JZ. Without it, both opcodes decode as illegal.
module cpu_controller_p #(
   parameter int              PC_W         = 7,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0,
   parameter int              WDOG_CYCLES  = 16
) (
   input  logic            Clk,
   input  logic            Rst,
   output logic [PC_W-1:0] PC_Out,
   output logic            IMem_Req,
   input  logic [15:0]     IMem_Q,
   input  logic            IMem_Valid,
   input  logic            Ra_Zero,
   output logic [15:0]     IR_Out,
   output logic [3:0]      OutState,
   output logic [3:0]      NextState,
   output logic [7:0]      D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_Addr,
   output logic [3:0]      RF_Rb_Addr,
   output logic [3:0]      RF_W_Addr,
   output logic [2:0]      ALU_s0,
   output logic            Halted,
   output logic            Fault,
   output logic            Illegal_Op
);

   // Counter only needs to reach WDOG_CYCLES-1; leaving WAIT happens there.
   localparam int              CNT_W    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_WAIT   = 4'd2,
      S_DECODE = 4'd3,
      S_NOOP   = 4'd4,
      S_LOAD_A = 4'd5,
      S_LOAD_B = 4'd6,
      S_STORE  = 4'd7,
      S_ADD    = 4'd8,
      S_SUB    = 4'd9,
      S_HALT   = 4'd10,
      S_JMP    = 4'd11,
      S_JZ     = 4'd12,
      S_FAULT  = 4'd13
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [PC_W-1:0]  r_pc;
   logic [15:0]      r_ir;
   logic [CNT_W-1:0] r_cnt;
   logic             r_illegal;
   logic             w_op_legal;

`ifndef CTRL_BRANCH_EN
   // Branch flag has no consumer when branches are compiled out.
   logic w_unused_ra_zero;
   assign w_unused_ra_zero = Ra_Zero;
`endif

   // Next-state decode, including opcode legality for the sticky flag.
   always_comb begin
      w_next     = r_state;
      w_op_legal = 1'b1;
      case (r_state)
         S_INIT:   w_next = S_FETCH;
         S_FETCH:  w_next = S_WAIT;
         S_WAIT: begin
            if (IMem_Valid)            w_next = S_DECODE;
            else if (r_cnt == CNT_LAST) w_next = S_FAULT;
         end
         S_DECODE: begin
            case (r_ir[15:12])
               4'h0: w_next = S_NOOP;
               4'h1: w_next = S_STORE;
               4'h2: w_next = S_LOAD_A;
               4'h3: w_next = S_ADD;
               4'h4: w_next = S_SUB;
               4'h5: w_next = S_HALT;
`ifdef CTRL_BRANCH_EN
               4'h6: w_next = S_JMP;
               4'h7: w_next = S_JZ;
`endif
               default: begin
                  w_next     = S_NOOP;
                  w_op_legal = 1'b0;
               end
            endcase
         end
         S_LOAD_A: w_next = S_LOAD_B;
         S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB, S_JMP, S_JZ:
                   w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_INIT;
      endcase
   end

   // State, PC, IR, watchdog and sticky illegal-opcode flag.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state   <= S_INIT;
         r_pc      <= RESET_VECTOR;
         r_ir      <= '0;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_WAIT: begin
               if (IMem_Valid) begin
                  r_ir  <= IMem_Q;
                  r_pc  <= r_pc + PC_W'(1);
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DECODE: begin
               if (!w_op_legal) r_illegal <= 1'b1;
            end
`ifdef CTRL_BRANCH_EN
            S_JMP: r_pc <= r_ir[PC_W-1:0];
            S_JZ: begin
               if (Ra_Zero) r_pc <= r_ir[PC_W-1:0];
            end
`endif
            default: ;
         endcase
      end
   end

   // Datapath controls decoded from the current state and IR.
   always_comb begin
      IMem_Req   = 1'b0;
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_en    = 1'b0;
      RF_Ra_Addr = '0;
      RF_Rb_Addr = '0;
      RF_W_Addr  = '0;
      ALU_s0     = '0;
      case (r_state)
         S_FETCH: IMem_Req = 1'b1;
         S_STORE: begin
            D_Addr     = r_ir[11:4];
            RF_Ra_Addr = r_ir[3:0];
            D_Wr       = 1'b1;
         end
         S_LOAD_A: begin
            D_Addr    = r_ir[11:4];
            RF_s      = 1'b1;
            RF_W_Addr = r_ir[3:0];
         end
         S_LOAD_B: begin
            D_Addr    = r_ir[11:4];
            RF_s      = 1'b1;
            RF_W_Addr = r_ir[3:0];
            RF_W_en   = 1'b1;
         end
         S_ADD, S_SUB: begin
            RF_Ra_Addr = r_ir[11:8];
            RF_Rb_Addr = r_ir[7:4];
            RF_W_Addr  = r_ir[3:0];
            RF_W_en    = 1'b1;
            ALU_s0     = (r_state == S_ADD) ? 3'd1 : 3'd2;
         end
         S_JZ: RF_Ra_Addr = r_ir[11:8];
         default: ;
      endcase
   end

   assign PC_Out     = r_pc;
   assign IR_Out     = r_ir;
   assign OutState   = r_state;
   assign NextState  = w_next;
   assign Halted     = (r_state == S_HALT);
   assign Fault      = (r_state == S_FAULT);
   assign Illegal_Op = r_illegal;

endmodule

// File: tb/tb_cpu_controller_p.sv
// Scoreboard bench for cpu_controller_p: a behavioural instruction memory
// answers fetches, stimulus queues expected snapshots, and a monitor compares
// on every entry into INIT or an execute/terminal state, or on a probe.
module tb_cpu_controller_p;
   localparam int PC_W = 7;

   logic            Clk = 1'b0;
   logic            Rst = 1'b1;
   logic [PC_W-1:0] PC_Out;
   logic            IMem_Req;
   logic [15:0]     IMem_Q = '0;
   logic            IMem_Valid = 1'b0;
   logic            Ra_Zero = 1'b0;
   logic [15:0]     IR_Out;
   logic [3:0]      OutState, NextState;
   logic [7:0]      D_Addr;
   logic            D_Wr, RF_s, RF_W_en;
   logic [3:0]      RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr;
   logic [2:0]      ALU_s0;
   logic            Halted, Fault, Illegal_Op;

   cpu_controller_p #(.PC_W(PC_W), .RESET_VECTOR(7'd0), .WDOG_CYCLES(16)) dut (
      .Clk(Clk), .Rst(Rst), .PC_Out(PC_Out), .IMem_Req(IMem_Req),
      .IMem_Q(IMem_Q), .IMem_Valid(IMem_Valid), .Ra_Zero(Ra_Zero),
      .IR_Out(IR_Out), .OutState(OutState), .NextState(NextState),
      .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
      .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .RF_W_Addr(RF_W_Addr),
      .ALU_s0(ALU_s0), .Halted(Halted), .Fault(Fault), .Illegal_Op(Illegal_Op)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0]  st;
      logic [6:0]  pc;
      logic [15:0] ir;
      logic [7:0]  daddr;
      logic        dwr;
      logic        rfs;
      logic        wen;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  wa;
      logic [2:0]  alu;
      logic        halted;
      logic        fault;
      logic        ill;
      logic [4:0]  wc;
      logic [3:0]  rc;
   } snap_t;

   snap_t exp_q[$];
   string name_q[$];
   int    n_chk = 0, n_pass = 0;
   int    s_chk = 0, s_pass = 0;
   bit    probe = 1'b0;

   logic [15:0] imem [0:127];
   int          mem_delay = 0;
   bit          withhold = 1'b0;

   // Instruction memory: answers a request after one WAIT cycle plus mem_delay.
   initial begin : mem_model
      logic [6:0] a;
      forever begin
         @(posedge Clk); #1;
         if (IMem_Req && !Rst) begin
            a = PC_Out;
            @(posedge Clk); #1;
            repeat (mem_delay) begin @(posedge Clk); #1; end
            if (!withhold) begin
               IMem_Q     = imem[a];
               IMem_Valid = 1'b1;
               @(posedge Clk); #1;
               IMem_Valid = 1'b0;
            end
         end
      end
   end

   // Monitor: NextState trace, fetch statistics, snapshot comparison.
   logic [3:0] prev_st = 4'hF;
   logic [3:0] prev_ns = 4'h0;
   logic       prev_rst = 1'b1;
   logic [4:0] wc = '0;
   logic [3:0] rc = '0;

   always @(negedge Clk) begin : mon
      snap_t act, e;
      string nm;
      if (!prev_rst) begin
         n_chk++;
         if (OutState === prev_ns) n_pass++;
         else $display("FAIL next_state_trace got=%0d exp=%0d", OutState, prev_ns);
      end
      prev_ns  = NextState;
      prev_rst = Rst;
      case (OutState)
         4'd0: begin wc = '0; rc = '0; end
         4'd1: begin wc = '0; rc = 4'(IMem_Req); end
         4'd2: begin wc = wc + 5'd1; rc = rc + 4'(IMem_Req); end
         default: ;
      endcase
      if ((OutState != prev_st && (OutState == 4'd0 || OutState >= 4'd4)) || probe) begin
         act = '{st: OutState, pc: PC_Out, ir: IR_Out, daddr: D_Addr, dwr: D_Wr,
                 rfs: RF_s, wen: RF_W_en, ra: RF_Ra_Addr, rb: RF_Rb_Addr,
                 wa: RF_W_Addr, alu: ALU_s0, halted: Halted, fault: Fault,
                 ill: Illegal_Op, wc: wc, rc: rc};
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event got=%h exp=none", act);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (act === e) n_pass++;
            else $display("FAIL %s got=%h exp=%h", nm, act, e);
         end
      end
      prev_st = OutState;
   end

   function automatic snap_t mk(input logic [3:0] st, input logic [6:0] pc,
                                input logic [15:0] ir, input logic ill,
                                input logic [4:0] w, input logic [3:0] r);
      snap_t s;
      s     = '0;
      s.st  = st;
      s.pc  = pc;
      s.ir  = ir;
      s.ill = ill;
      s.wc  = w;
      s.rc  = r;
      return s;
   endfunction

   task automatic push(input string nm, input snap_t s);
      exp_q.push_back(s);
      name_q.push_back(nm);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      push("reset_init", mk(4'd0, 7'd0, 16'h0000, 1'b0, 5'd0, 4'd0));
      Rst = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
   endtask

   task automatic do_probe(input string nm, input snap_t s);
      push(nm, s);
      probe = 1'b1;
      @(posedge Clk); #1;
      probe = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] st, input int budget, input string nm);
      int n;
      n = 0;
      s_chk++;
      while (OutState !== st && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (OutState === st) s_pass++;
      else $display("FAIL %s got_state=%0d exp_state=%0d (timeout)", nm, OutState, st);
      @(posedge Clk); #1;
   endtask

   initial begin : global_limit
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      snap_t s;
      int    n;
      // ADD then HALT, zero-wait memory
      clear_mem();
      imem[0] = 16'h3123;
      imem[1] = 16'h5000;
      do_reset();
      s = mk(4'd8, 7'd1, 16'h3123, 1'b0, 5'd1, 4'd1);
      s.ra = 4'd1; s.rb = 4'd2; s.wa = 4'd3; s.alu = 3'd1; s.wen = 1'b1;
      push("add_exec", s);
      s = mk(4'd10, 7'd2, 16'h5000, 1'b0, 5'd1, 4'd1);
      s.halted = 1'b1;
      push("halt_entry", s);
      wait_state(4'd10, 100, "t1_reach_halt");
      repeat (4) @(posedge Clk); #1;
      do_probe("halt_frozen", s);

      // LOAD (two phases) then STORE
      clear_mem();
      imem[0] = 16'h2A57;
      imem[1] = 16'h1A57;
      imem[2] = 16'h5000;
      do_reset();
      s = mk(4'd5, 7'd1, 16'h2A57, 1'b0, 5'd1, 4'd1);
      s.daddr = 8'hA5; s.rfs = 1'b1; s.wa = 4'd7;
      push("load_a", s);
      s.st = 4'd6; s.wen = 1'b1;
      push("load_b", s);
      s = mk(4'd7, 7'd2, 16'h1A57, 1'b0, 5'd1, 4'd1);
      s.daddr = 8'hA5; s.ra = 4'd7; s.dwr = 1'b1;
      push("store", s);
      s = mk(4'd10, 7'd3, 16'h5000, 1'b0, 5'd1, 4'd1);
      s.halted = 1'b1;
      push("halt_after_store", s);
      wait_state(4'd10, 100, "t2_reach_halt");

      // Wait states: five WAIT cycles per fetch, single request pulse
      clear_mem();
      imem[1] = 16'h5000;
      mem_delay = 4;
      do_reset();
      push("noop_slow_mem", mk(4'd4, 7'd1, 16'h0000, 1'b0, 5'd5, 4'd1));
      s = mk(4'd10, 7'd2, 16'h5000, 1'b0, 5'd5, 4'd1);
      s.halted = 1'b1;
      push("halt_slow_mem", s);
      wait_state(4'd10, 200, "t3_reach_halt");
      mem_delay = 0;

      // Watchdog: no word ever arrives
      clear_mem();
      withhold = 1'b1;
      do_reset();
      s = mk(4'd13, 7'd0, 16'h0000, 1'b0, 5'd16, 4'd1);
      s.fault = 1'b1;
      push("watchdog_fault", s);
      wait_state(4'd13, 100, "t3_reach_fault");
      repeat (4) @(posedge Clk); #1;
      do_probe("fault_frozen", s);
      withhold = 1'b0;

      // PC wrap at 0x7F plus illegal opcode 0xF
      clear_mem();
      imem[127] = 16'hF000;
      do_reset();
      for (int i = 1; i < 128; i++)
         push("noop_walk", mk(4'd4, 7'(i), 16'h0000, 1'b0, 5'd1, 4'd1));
      push("wrap_illegal", mk(4'd4, 7'd0, 16'hF000, 1'b1, 5'd1, 4'd1));
      s = mk(4'd10, 7'd1, 16'h5000, 1'b1, 5'd1, 4'd1);
      s.halted = 1'b1;
      push("halt_after_wrap", s);
      n = 0;
      while (PC_Out != 7'd1 && n < 50) begin @(posedge Clk); #1; n++; end
      imem[0] = 16'h5000;
      wait_state(4'd10, 2000, "t4_reach_halt");
      repeat (3) @(posedge Clk); #1;
      do_probe("illegal_sticky", s);

      // Branch opcodes
      clear_mem();
      Ra_Zero = 1'b1;
`ifdef CTRL_BRANCH_EN
      imem[0]  = 16'h6012;
      imem[18] = 16'h7305;
      imem[5]  = 16'h7305;
      imem[6]  = 16'h5000;
      do_reset();
      push("jmp", mk(4'd11, 7'd1, 16'h6012, 1'b0, 5'd1, 4'd1));
      s = mk(4'd12, 7'h13, 16'h7305, 1'b0, 5'd1, 4'd1);
      s.ra = 4'd3;
      push("jz_taken", s);
      s.pc = 7'd6;
      push("jz_not_taken", s);
      s = mk(4'd10, 7'd7, 16'h5000, 1'b0, 5'd1, 4'd1);
      s.halted = 1'b1;
      push("halt_after_jz", s);
      wait_state(4'd12, 100, "t5_reach_jz");
      Ra_Zero = 1'b0;
      wait_state(4'd10, 100, "t5_reach_halt");
`else
      imem[0] = 16'h6012;
      imem[1] = 16'h5000;
      do_reset();
      push("jmp_illegal", mk(4'd4, 7'd1, 16'h6012, 1'b1, 5'd1, 4'd1));
      s = mk(4'd10, 7'd2, 16'h5000, 1'b1, 5'd1, 4'd1);
      s.halted = 1'b1;
      push("halt_after_jmp_illegal", s);
      wait_state(4'd10, 100, "t5_reach_halt");
`endif
      Ra_Zero = 1'b0;

      // Reset in WAIT while the word arrives in the same cycle
      clear_mem();
      imem[0] = 16'h3123;
      mem_delay = 2;
      do_reset();
      n = 0;
      s_chk++;
      while (n < 50) begin
         @(posedge Clk); #2;
         if (IMem_Valid) break;
         n++;
      end
      if (IMem_Valid && OutState == 4'd2) s_pass++;
      else $display("FAIL t6_valid_in_wait got_state=%0d exp_state=2", OutState);
      imem[0] = 16'h5000;
      mem_delay = 0;
      push("rst_in_wait", mk(4'd0, 7'd0, 16'h0000, 1'b0, 5'd0, 4'd0));
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      s = mk(4'd10, 7'd1, 16'h5000, 1'b0, 5'd1, 4'd1);
      s.halted = 1'b1;
      push("halt_after_rst_wait", s);
      wait_state(4'd10, 100, "t6_reach_halt");

      repeat (5) @(posedge Clk); #1;
      s_chk++;
      if (exp_q.size() == 0) s_pass++;
      else $display("FAIL queue_drained got=%0d exp=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass + s_pass, n_chk + s_chk);
      $finish;
   end
endmodule
